cordic_arbiter: RTL
===================

# cordic_arbiter

Round-robin scheduler that shares one pipelined `Cordic` sine/cosine core between `NREQ` requesters. It accepts at most one angle per clock from the requesters through valid/ready handshakes and drives the core's `angle`, `Xin` and `Yin` inputs. A tag delay line tracks each operation through the core's fixed latency, and each result is returned tagged with the originating requester's id. The block sits between the core and its client blocks (NCO, modulator, test sweeper) and is the only driver of the core's inputs.

## Interface
- `NREQ`, 4 — number of requesters (2..8).
- `BW`, 32 — core X/Y width; results are `BW+1` bits signed.
- `LAT`, 32 — core latency in clocks, from the edge that registers `angle` to the edge after which `Xout`/`Yout` hold that result.
- `XIN_INIT`, 32'h4DBA76D4 — constant X seed (1/K ≈ 0.607253 · 2^31).
- `master_clk`  in  1  — single clock, rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `enable`  in  1  — grants are allowed only while high; in-flight operations always drain.
- `req_valid`  in  NREQ  — requester i has an angle pending.
- `req_angle`  in  NREQ*32  — angle of requester i in bits [32i+31:32i]; full turn = 2^32.
- `req_ready`  out  NREQ  — one-hot grant; combinational from `req_valid`, `enable` and the pointer.
- `core_angle`  out  32  — registered angle to the core.
- `core_xin`  out  BW  — constant `XIN_INIT`.
- `core_yin`  out  BW  — constant 0.
- `core_xout`, `core_yout`  in  BW+1  — core results, signed.
- `rsp_valid`  out  1  — result strobe, one cycle per accepted request.
- `rsp_id`  out  $clog2(NREQ)  — index of the requester that issued the angle.
- `rsp_cos`, `rsp_sin`  out  BW+1  — registered `core_xout`/`core_yout`, scale 2^-31.
- `busy`  out  1  — high while any tag is in flight or `rsp_valid` is high.

## Operation
- Arbitration: `ptr` (reset 0). The grant goes to the first i with `req_valid[i]`, searching from `ptr` upward with wrap. No grant when `enable`=0 or no request is valid.
- A handshake on requester g at edge k does three things: `core_angle` ← `req_angle[g]`; `ptr` ← (g+1) mod NREQ; tag {1,g} enters the delay line.
- Without a grant: `core_angle` holds its value, a null tag enters the line, and `ptr` is unchanged.
- Delay line: LAT+1 stages of {valid,id}, shifting every clock. It never stalls because the core has no backpressure and the block has none downstream. Consumers must always accept `rsp_valid`.
- Output register: when the tag leaving the line is valid, `rsp_cos`/`rsp_sin` ← `core_xout`/`core_yout`, `rsp_id` ← tag id, and `rsp_valid`=1. Otherwise `rsp_valid`=0 and the data/id hold.
- Responses appear in strict issue order. Throughput is one result per clock when requests are sustained.
- Fairness: when all NREQ requesters are continuously valid, each one is granted exactly once in every NREQ consecutive cycles.
- Reset values: `core_angle`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_cos`=`rsp_sin`=0, `ptr`=0, all tags null, `busy`=0. `core_xin`/`core_yin` are constants.
- Reset mid-operation clears all tags immediately. In-flight results are discarded, and no `rsp_valid` appears for pre-reset requests.
- If `enable` falls while operations are in flight: no new grants, existing tags drain normally, and `busy` falls one cycle after the last `rsp_valid`.
- If a requester drops `req_valid` without a grant, nothing happens; no request is lost or duplicated.

## Timing
- Handshake at edge k → `core_angle` updated after edge k → `rsp_valid` is high for the cycle after edge k+LAT+1. Total latency is LAT+1 = 33 clocks at defaults.
- `req_ready` is combinational. Every other output is registered.
- `busy` is registered; it is the OR of the tag valids and `rsp_valid`.

## Configuration
- `CORDIC_ARB_STATS_EN` defined: adds output `grant_cnt` (NREQ*16). Requester i's counter is in bits [16i+15:16i], increments on each grant, saturates at 16'hFFFF and resets to 0.
- Not defined: the port and counters do not exist. All other behaviour is identical.

## Test plan
- Single request: after reset, requester 2 sends 32'h4000_0000 (90°) → exactly one `rsp_valid`, 33 clocks after the handshake, `rsp_id`=2, `rsp_cos`≈0, `rsp_sin`≈33'h0_8000_0000 (both ±2^-20).
- All four requesters continuously valid for 16 cycles → grants 0,1,2,3,0,1,… with no idle cycle; 16 responses in the same id order. With `CORDIC_ARB_STATS_EN`, each `grant_cnt` = 4.
- Sweep: one requester issues i·2^32/360 for i=0..359 back-to-back → 360 consecutive `rsp_valid`. Each cos/sin matches $cos/$sin(i°) within 2^-20; angle 0 gives `rsp_cos`≈33'h0_8000_0000.
- `enable` dropped with 10 operations in flight → `req_ready`=0 from the same cycle, 10 responses still delivered, `busy` low 1 cycle after the last one.
- `rst_n` pulsed low 5 cycles after 5 issues → all outputs at reset values, zero responses for those 5, `ptr`=0 (the next contest between requesters 0 and 3 grants 0).
- Requests on 1 and 3 with `ptr`=2 → grant 3, then 1 (wrap).

Source files
------------

// File: rtl/cordic_arbiter_if.sv
// cordic_arbiter_if: requester, core and response signals of the CORDIC arbiter.
// slave  = the arbiter itself.
// master = its environment (requesting clients and the CORDIC core).
interface cordic_arbiter_if #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned BW   = 32
);
   localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned AW  = 32;

   logic [NREQ-1:0]    req_valid;
   logic [NREQ*AW-1:0] req_angle;
   logic [NREQ-1:0]    req_ready;

   logic [AW-1:0]      core_angle;
   logic [BW-1:0]      core_xin;
   logic [BW-1:0]      core_yin;
   logic signed [BW:0] core_xout;
   logic signed [BW:0] core_yout;

   logic               rsp_valid;
   logic [IDW-1:0]     rsp_id;
   logic signed [BW:0] rsp_cos;
   logic signed [BW:0] rsp_sin;
   logic               busy;

   modport slave (
      input  req_valid, req_angle, core_xout, core_yout,
      output req_ready, core_angle, core_xin, core_yin,
             rsp_valid, rsp_id, rsp_cos, rsp_sin, busy
   );

   modport master (
      output req_valid, req_angle, core_xout, core_yout,
      input  req_ready, core_angle, core_xin, core_yin,
             rsp_valid, rsp_id, rsp_cos, rsp_sin, busy
   );
endinterface

// File: rtl/cordic_arbiter.sv
// cordic_arbiter: round-robin front end sharing one pipelined CORDIC sin/cos
// core between NREQ requesters. A tag line matching the core latency carries
// the requester id so results come back in issue order with their id.
// Optional feature macro: CORDIC_ARB_STATS_EN adds saturating per-requester
// grant counters on output grant_cnt.
module cordic_arbiter #(
   parameter int unsigned   NREQ     = 4,
   parameter int unsigned   BW       = 32,
   parameter int unsigned   LAT      = 32,
   parameter logic [BW-1:0] XIN_INIT = BW'(32'h4DBA76D4)
) (
   input  logic               master_clk,
   input  logic               rst_n,
   input  logic               enable,
   cordic_arbiter_if.slave    bus
`ifdef CORDIC_ARB_STATS_EN
   ,
   output logic [NREQ*16-1:0] grant_cnt
`endif
);
   localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned AW  = 32;
   localparam int unsigned CW  = 16;

   typedef struct packed {
      logic           vld;
      logic [IDW-1:0] id;
   } tag_t;

   logic [IDW-1:0]  ptr_q;
   logic            grant_c;
   logic [IDW-1:0]  gnt_id_c;
   logic [NREQ-1:0] ready_c;
   logic [IDW:0]    idx_c;
   logic [AW-1:0]   gnt_angle_c;
   logic            busy_nxt_c;
   tag_t            tag_q [LAT+1];

   // Round-robin search: first valid requester at or after ptr, with wrap.
   always_comb begin
      grant_c  = 1'b0;
      gnt_id_c = '0;
      ready_c  = '0;
      idx_c    = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx_c = {1'b0, ptr_q} + (IDW+1)'(k);
         if (idx_c >= (IDW+1)'(NREQ)) begin
            idx_c = idx_c - (IDW+1)'(NREQ);
         end
         if (enable && !grant_c && bus.req_valid[idx_c[IDW-1:0]]) begin
            grant_c  = 1'b1;
            gnt_id_c = idx_c[IDW-1:0];
         end
      end
      if (grant_c) begin
         ready_c[gnt_id_c] = 1'b1;
      end
   end

   // Angle of the granted requester.
   always_comb begin
      gnt_angle_c = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (gnt_id_c == IDW'(k)) begin
            gnt_angle_c = bus.req_angle[AW*k +: AW];
         end
      end
   end

   assign bus.req_ready = ready_c;
   assign bus.core_xin  = XIN_INIT;
   assign bus.core_yin  = '0;

   // Issue: register the granted angle and move the pointer past the winner.
   always_ff @(posedge master_clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q          <= '0;
         bus.core_angle <= '0;
      end else if (grant_c) begin
         bus.core_angle <= gnt_angle_c;
         ptr_q          <= (gnt_id_c == IDW'(NREQ-1)) ? '0 : gnt_id_c + IDW'(1);
      end
   end

   // Tag line: one {valid,id} per clock, aligned with the core pipeline.
   always_ff @(posedge master_clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i <= LAT; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         tag_q[0] <= '{vld: grant_c, id: gnt_id_c};
         for (int unsigned i = 1; i <= LAT; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   // Next busy: anything entering or already in the line, or about to be output.
   always_comb begin
      busy_nxt_c = grant_c;
      for (int unsigned i = 0; i <= LAT; i++) begin
         busy_nxt_c = busy_nxt_c | tag_q[i].vld;
      end
   end

   // Response register: capture core result when the matching tag leaves.
   always_ff @(posedge master_clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.rsp_valid <= 1'b0;
         bus.rsp_id    <= '0;
         bus.rsp_cos   <= '0;
         bus.rsp_sin   <= '0;
         bus.busy      <= 1'b0;
      end else begin
         bus.rsp_valid <= tag_q[LAT].vld;
         bus.busy      <= busy_nxt_c;
         if (tag_q[LAT].vld) begin
            bus.rsp_id  <= tag_q[LAT].id;
            bus.rsp_cos <= bus.core_xout;
            bus.rsp_sin <= bus.core_yout;
         end
      end
   end

`ifdef CORDIC_ARB_STATS_EN
   // Saturating grant counter per requester.
   always_ff @(posedge master_clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_cnt <= '0;
      end else begin
         for (int unsigned k = 0; k < NREQ; k++) begin
            if (grant_c && gnt_id_c == IDW'(k) &&
                grant_cnt[CW*k +: CW] != {CW{1'b1}}) begin
               grant_cnt[CW*k +: CW] <= grant_cnt[CW*k +: CW] + CW'(1);
            end
         end
      end
   end
`endif

endmodule
